// File: rtl/iec_bus_ctrl.sv
// Device-level IEC bus sequencer: decodes ATN commands, tracks listener/talker role,
// buffers received listener bytes in a FIFO and feeds host talk bytes to the engine.
module iec_bus_ctrl #(
  parameter logic [4:0] DEVICE_ADDR = 5'd8,
  parameter int         FIFO_DEPTH  = 8,
  parameter int         TURN_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       atn,
  input  logic [7:0] rx_byte,
  input  logic       rx_ready,
  input  logic       rx_eoi,
  output logic [7:0] tx_byte,
  output logic       tx_ready,
  input  logic       tx_ack,
  output logic       engine_talk,
  output logic [7:0] lst_data,
  output logic       lst_last,
  output logic       lst_valid,
  input  logic       lst_pop,
  input  logic [7:0] tlk_data,
  input  logic       tlk_last,
  input  logic       tlk_valid,
  output logic       tlk_take,
  output logic [3:0] sec_addr,
  output logic       cmd_open,
  output logic       cmd_close,
  output logic       listening,
  output logic       talking,
  output logic       overflow
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int CW    = (TURN_CYCLES < 1) ? 1 : $clog2(TURN_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_LISTEN, S_TURN, S_TALK} state_t;

  state_t           state_q, state_d;
  logic             atn_q, atn_d;
  logic             listen_q, listen_d;
  logic             talk_q, talk_d;
  logic [3:0]       sec_addr_q, sec_addr_d;
  logic             cmd_open_q, cmd_open_d;
  logic             cmd_close_q, cmd_close_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             tx_ready_q, tx_ready_d;
  logic             tx_last_q, tx_last_d;
  logic             engine_talk_q, engine_talk_d;
  logic             overflow_q, overflow_d;
  logic [CW-1:0]    turn_cnt_q, turn_cnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [8:0] fifo_mem [FIFO_DEPTH];
  logic       fifo_wr, fifo_rd, fifo_full;
  logic       atn_fall, atn_rise, is_secondary, tlk_take_c;

  assign atn_fall     = atn_q & ~atn;
  assign atn_rise     = ~atn_q & atn;
  assign fifo_full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign is_secondary = (rx_byte[7:4] == 4'h6) || (rx_byte[7:4] == 4'hE) || (rx_byte[7:4] == 4'hF);

  always_comb begin
    state_d     = state_q;
    atn_d       = atn;
    listen_d    = listen_q;
    talk_d      = talk_q;
    sec_addr_d  = sec_addr_q;
    cmd_open_d  = 1'b0;
    cmd_close_d = 1'b0;
    tx_byte_d   = tx_byte_q;
    tx_ready_d  = tx_ready_q;
    tx_last_d   = tx_last_q;
    overflow_d  = overflow_q;
    turn_cnt_d  = turn_cnt_q;
    fifo_wr     = 1'b0;
    fifo_rd     = lst_pop && (count_q != '0);
    tlk_take_c  = 1'b0;

    case (state_q)
      S_CMD: begin
        if (rx_ready) begin
          if (rx_byte[7:5] == 3'b001) begin
            // UNLISTEN (0x3F) takes precedence over an address match
            if (rx_byte[4:0] == DEVICE_ADDR && rx_byte != 8'h3F) begin
              listen_d = 1'b1;
              talk_d   = 1'b0;
            end else begin
              listen_d = 1'b0;
            end
          end else if (rx_byte[7:5] == 3'b010) begin
            if (rx_byte[4:0] == DEVICE_ADDR && rx_byte != 8'h5F) begin
              talk_d   = 1'b1;
              listen_d = 1'b0;
            end else begin
              talk_d = 1'b0;
            end
          end else if (is_secondary && (listen_q || talk_q)) begin
            sec_addr_d  = rx_byte[3:0];
            cmd_close_d = (rx_byte[7:4] == 4'hE);
            cmd_open_d  = (rx_byte[7:4] == 4'hF);
          end
        end
        if (atn_rise) begin
          if (listen_q) begin
            state_d = S_LISTEN;
          end else if (talk_q) begin
            state_d    = S_TURN;
            turn_cnt_d = CW'(TURN_CYCLES);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_LISTEN: begin
        // A same-cycle pop frees a slot, so a write on a full FIFO still lands
        if (rx_ready) begin
          if (!fifo_full || fifo_rd) fifo_wr = 1'b1;
          else                       overflow_d = 1'b1;
        end
      end
      S_TURN: begin
        if (turn_cnt_q <= CW'(1)) state_d = S_TALK;
        else                      turn_cnt_d = turn_cnt_q - CW'(1);
      end
      S_TALK: begin
        if (tx_ready_q) begin
          if (tx_ack) begin
            tx_ready_d = 1'b0;
            if (tx_last_q) begin
              talk_d  = 1'b0;
              state_d = S_IDLE;
            end
          end
        end else if (tlk_valid) begin
          tx_byte_d  = tlk_data;
          tx_last_d  = tlk_last;
          tx_ready_d = 1'b1;
          tlk_take_c = 1'b1;
        end
      end
      default: ;
    endcase

    // ATN assertion preempts everything; a pending talk byte is abandoned
    if (atn_fall) begin
      state_d    = S_CMD;
      tx_ready_d = 1'b0;
      tlk_take_c = 1'b0;
    end

    engine_talk_d = (state_d == S_TALK);

    wr_ptr_d = fifo_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = fifo_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (fifo_wr && !fifo_rd)      count_d = count_q + CNT_W'(1);
    else if (!fifo_wr && fifo_rd) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      atn_q         <= 1'b1;
      listen_q      <= 1'b0;
      talk_q        <= 1'b0;
      sec_addr_q    <= '0;
      cmd_open_q    <= 1'b0;
      cmd_close_q   <= 1'b0;
      tx_byte_q     <= '0;
      tx_ready_q    <= 1'b0;
      tx_last_q     <= 1'b0;
      engine_talk_q <= 1'b0;
      overflow_q    <= 1'b0;
      turn_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      atn_q         <= atn_d;
      listen_q      <= listen_d;
      talk_q        <= talk_d;
      sec_addr_q    <= sec_addr_d;
      cmd_open_q    <= cmd_open_d;
      cmd_close_q   <= cmd_close_d;
      tx_byte_q     <= tx_byte_d;
      tx_ready_q    <= tx_ready_d;
      tx_last_q     <= tx_last_d;
      engine_talk_q <= engine_talk_d;
      overflow_q    <= overflow_d;
      turn_cnt_q    <= turn_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr_q] <= {rx_eoi, rx_byte};
  end

  assign lst_valid   = (count_q != '0);
  assign lst_data    = lst_valid ? fifo_mem[rd_ptr_q][7:0] : 8'h00;
  assign lst_last    = lst_valid ? fifo_mem[rd_ptr_q][8] : 1'b0;
  assign tx_byte     = tx_byte_q;
  assign tx_ready    = tx_ready_q;
  assign engine_talk = engine_talk_q;
  assign tlk_take    = tlk_take_c;
  assign sec_addr    = sec_addr_q;
  assign cmd_open    = cmd_open_q;
  assign cmd_close   = cmd_close_q;
  assign listening   = listen_q;
  assign talking     = talk_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_iec_bus_ctrl.sv
// Directed bench for iec_bus_ctrl: a per-cycle vector table for command decode and
// listener flow, plus hand-written sequences for turnaround, talk, overflow and reset.
module tb_iec_bus_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       atn;
  logic [7:0] rx_byte;
  logic       rx_ready;
  logic       rx_eoi;
  logic [7:0] tx_byte;
  logic       tx_ready;
  logic       tx_ack;
  logic       engine_talk;
  logic [7:0] lst_data;
  logic       lst_last;
  logic       lst_valid;
  logic       lst_pop;
  logic [7:0] tlk_data;
  logic       tlk_last;
  logic       tlk_valid;
  logic       tlk_take;
  logic [3:0] sec_addr;
  logic       cmd_open;
  logic       cmd_close;
  logic       listening;
  logic       talking;
  logic       overflow;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  iec_bus_ctrl dut (
    .clk(clk), .reset(reset), .atn(atn),
    .rx_byte(rx_byte), .rx_ready(rx_ready), .rx_eoi(rx_eoi),
    .tx_byte(tx_byte), .tx_ready(tx_ready), .tx_ack(tx_ack),
    .engine_talk(engine_talk),
    .lst_data(lst_data), .lst_last(lst_last), .lst_valid(lst_valid), .lst_pop(lst_pop),
    .tlk_data(tlk_data), .tlk_last(tlk_last), .tlk_valid(tlk_valid), .tlk_take(tlk_take),
    .sec_addr(sec_addr), .cmd_open(cmd_open), .cmd_close(cmd_close),
    .listening(listening), .talking(talking), .overflow(overflow)
  );

  typedef struct {
    logic       atn;
    logic       rxv;
    logic [7:0] rxb;
    logic       eoi;
    logic       pop;
    logic       lst;
    logic       tlk;
    logic [3:0] sa;
    logic       op;
    logic       cl;
    logic       lv;
    logic [8:0] head;
  } vec_t;

  vec_t vq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic rx(input logic [7:0] b, input logic e);
    rx_byte  = b;
    rx_eoi   = e;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    rx_eoi   = 1'b0;
  endtask

  task automatic add(input logic a, input logic v, input logic [7:0] b, input logic e,
                     input logic p, input logic l, input logic t, input logic [3:0] s,
                     input logic o, input logic c, input logic lv, input logic [8:0] h);
    vec_t x;
    x.atn = a; x.rxv = v; x.rxb = b; x.eoi = e; x.pop = p;
    x.lst = l; x.tlk = t; x.sa = s; x.op = o; x.cl = c; x.lv = lv; x.head = h;
    vq.push_back(x);
  endtask

  initial begin
    int n;
    reset = 1'b1; atn = 1'b1; rx_byte = 8'h00; rx_ready = 1'b0; rx_eoi = 1'b0;
    tx_ack = 1'b0; lst_pop = 1'b0; tlk_data = 8'h00; tlk_last = 1'b0; tlk_valid = 1'b0;

    //   atn rxv  rxb  eoi pop  lst tlk sa  op cl lv head
    add(0, 0, 8'h00, 0, 0,   0, 0, 4'd0, 0, 0, 0, 9'h000); // ATN falls
    add(0, 1, 8'h28, 0, 0,   1, 0, 4'd0, 0, 0, 0, 9'h000); // LISTEN 8
    add(0, 1, 8'h60, 0, 0,   1, 0, 4'd0, 0, 0, 0, 9'h000); // secondary 0, no pulse
    add(1, 0, 8'h00, 0, 0,   1, 0, 4'd0, 0, 0, 0, 9'h000); // ATN rises -> LISTEN
    add(1, 1, 8'h42, 0, 0,   1, 0, 4'd0, 0, 0, 1, 9'h042);
    add(1, 1, 8'h7B, 1, 0,   1, 0, 4'd0, 0, 0, 1, 9'h042);
    add(1, 0, 8'h00, 0, 1,   1, 0, 4'd0, 0, 0, 1, 9'h17B);
    add(1, 0, 8'h00, 0, 1,   1, 0, 4'd0, 0, 0, 0, 9'h000);
    add(0, 0, 8'h00, 0, 0,   1, 0, 4'd0, 0, 0, 0, 9'h000); // role survives ATN
    add(0, 1, 8'h29, 0, 0,   0, 0, 4'd0, 0, 0, 0, 9'h000); // other device
    add(1, 0, 8'h00, 0, 0,   0, 0, 4'd0, 0, 0, 0, 9'h000); // -> IDLE
    add(1, 1, 8'h55, 0, 0,   0, 0, 4'd0, 0, 0, 0, 9'h000); // ignored in IDLE
    add(0, 0, 8'h00, 0, 0,   0, 0, 4'd0, 0, 0, 0, 9'h000);
    add(0, 1, 8'h48, 0, 0,   0, 1, 4'd0, 0, 0, 0, 9'h000); // TALK 8
    add(0, 1, 8'h28, 0, 0,   1, 0, 4'd0, 0, 0, 0, 9'h000); // LISTEN clears talk
    add(0, 1, 8'hF3, 0, 0,   1, 0, 4'd3, 1, 0, 0, 9'h000); // OPEN 3
    add(0, 0, 8'h00, 0, 0,   1, 0, 4'd3, 0, 0, 0, 9'h000); // pulse ends
    add(0, 1, 8'hE5, 0, 0,   1, 0, 4'd5, 0, 1, 0, 9'h000); // CLOSE 5
    add(0, 1, 8'h3F, 0, 0,   0, 0, 4'd5, 0, 0, 0, 9'h000); // UNLISTEN
    add(0, 1, 8'h65, 0, 0,   0, 0, 4'd5, 0, 0, 0, 9'h000); // unaddressed secondary
    add(0, 1, 8'h48, 0, 0,   0, 1, 4'd5, 0, 0, 0, 9'h000);
    add(0, 1, 8'h5F, 0, 0,   0, 0, 4'd5, 0, 0, 0, 9'h000); // UNTALK
    add(0, 1, 8'h48, 0, 0,   0, 1, 4'd5, 0, 0, 0, 9'h000);
    add(0, 1, 8'h49, 0, 0,   0, 0, 4'd5, 0, 0, 0, 9'h000); // other talker
    add(0, 1, 8'h28, 0, 0,   1, 0, 4'd5, 0, 0, 0, 9'h000);
    add(0, 1, 8'h7F, 0, 0,   1, 0, 4'd5, 0, 0, 0, 9'h000); // unused code
    add(0, 1, 8'h48, 0, 0,   0, 1, 4'd5, 0, 0, 0, 9'h000); // TALK clears listen
    add(0, 1, 8'h5F, 0, 0,   0, 0, 4'd5, 0, 0, 0, 9'h000);
    add(1, 0, 8'h00, 0, 0,   0, 0, 4'd5, 0, 0, 0, 9'h000);

    repeat (3) tick();
    reset = 1'b0;
    chk("reset tx_ready", tx_ready, 0);
    chk("reset tx_byte", tx_byte, 0);
    chk("reset engine_talk", engine_talk, 0);
    chk("reset lst_valid", lst_valid, 0);
    chk("reset lst_data", {lst_last, lst_data}, 0);
    chk("reset roles", {listening, talking}, 0);
    chk("reset sec_addr", sec_addr, 0);
    chk("reset pulses", {cmd_open, cmd_close, tlk_take}, 0);
    chk("reset overflow", overflow, 0);

    foreach (vq[i]) begin
      atn = vq[i].atn; rx_ready = vq[i].rxv; rx_byte = vq[i].rxb;
      rx_eoi = vq[i].eoi; lst_pop = vq[i].pop;
      tick();
      rx_ready = 1'b0; rx_eoi = 1'b0; lst_pop = 1'b0;
      chk($sformatf("v%0d listening", i), listening, vq[i].lst);
      chk($sformatf("v%0d talking", i), talking, vq[i].tlk);
      chk($sformatf("v%0d sec_addr", i), sec_addr, vq[i].sa);
      chk($sformatf("v%0d open/close", i), {cmd_open, cmd_close}, {vq[i].op, vq[i].cl});
      chk($sformatf("v%0d lst_valid", i), lst_valid, vq[i].lv);
      chk($sformatf("v%0d head", i), {lst_last, lst_data}, vq[i].head);
      chk($sformatf("v%0d engine_talk", i), engine_talk, 0);
    end

    // Talker: OPEN pulse, turnaround length, two-byte transfer ending with last
    atn = 1'b0; tick();
    rx(8'h48, 0);
    rx_byte = 8'hF2; rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    chk("talk open pulse", cmd_open, 1);
    chk("talk sec_addr", sec_addr, 2);
    tick();
    chk("talk open clears", cmd_open, 0);
    atn = 1'b1; tick();
    n = 0;
    while (!engine_talk && n < 40) begin tick(); n++; end
    chk("turnaround cycles", n, 16);
    tlk_data = 8'hAA; tlk_last = 1'b0; tlk_valid = 1'b1;
    @(negedge clk);
    chk("tlk_take AA", tlk_take, 1);
    tick();
    tlk_data = 8'hBB; tlk_last = 1'b1;
    chk("tx AA ready", {tx_ready, tx_byte}, 9'h1AA);
    @(negedge clk);
    chk("tlk_take held off", tlk_take, 0);
    tick(); tick();
    chk("tx AA held", {tx_ready, tx_byte}, 9'h1AA);
    tx_ack = 1'b1; tick(); tx_ack = 1'b0;
    chk("tx AA acked", tx_ready, 0);
    @(negedge clk);
    chk("tlk_take BB", tlk_take, 1);
    tick();
    tlk_valid = 1'b0;
    chk("tx BB ready", {tx_ready, tx_byte}, 9'h1BB);
    chk("talking during BB", talking, 1);
    tx_ack = 1'b1; tick(); tx_ack = 1'b0;
    chk("after last", {tx_ready, talking, engine_talk}, 0);

    // Overflow and write-with-pop on a full FIFO
    atn = 1'b0; tick();
    rx(8'h28, 0);
    atn = 1'b1; tick();
    for (int i = 0; i < 8; i++) rx(8'h10 + 8'(i), 0);
    chk("full no overflow", overflow, 0);
    chk("full head", {lst_valid, lst_data}, 9'h110);
    rx_byte = 8'h18; rx_ready = 1'b1; lst_pop = 1'b1; tick();
    rx_ready = 1'b0; lst_pop = 1'b0;
    chk("pop+write no drop", overflow, 0);
    chk("pop+write head", lst_data, 8'h11);
    rx(8'h19, 0);
    chk("ninth dropped", overflow, 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain %0d", i), {lst_valid, lst_data}, {1'b1, 8'h11 + 8'(i)});
      lst_pop = 1'b1; tick(); lst_pop = 1'b0;
    end
    chk("drained empty", lst_valid, 0);
    lst_pop = 1'b1; tick(); lst_pop = 1'b0;
    chk("pop on empty", lst_valid, 0);
    rx(8'h20, 1);
    chk("after wrap", {lst_valid, lst_last, lst_data}, 10'h320);

    // Reset in LISTEN with three queued bytes
    rx(8'h21, 0);
    rx(8'h22, 0);
    chk("pre-reset listening", {listening, lst_valid}, 2'b11);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid reset lst_valid", lst_valid, 0);
    chk("mid reset roles", {listening, talking}, 0);
    chk("mid reset overflow", overflow, 0);
    rx(8'h30, 0);
    chk("idle after reset", lst_valid, 0);

    // ATN falling while a talk byte is pending
    atn = 1'b0; tick();
    rx(8'h48, 0);
    atn = 1'b1; tick();
    n = 0;
    while (!engine_talk && n < 40) begin tick(); n++; end
    chk("talk2 engine_talk", engine_talk, 1);
    tlk_data = 8'hC3; tlk_last = 1'b0; tlk_valid = 1'b1; tick(); tlk_valid = 1'b0;
    chk("talk2 tx_ready", {tx_ready, tx_byte}, 9'h1C3);
    atn = 1'b0; tick();
    chk("abort tx_ready", tx_ready, 0);
    chk("abort engine_talk", engine_talk, 0);
    chk("abort still talker", talking, 1);
    rx(8'h5F, 0);
    chk("untalk", talking, 0);
    atn = 1'b1; tick();
    repeat (20) tick();
    chk("idle after untalk", {engine_talk, talking, tx_ready}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
